// File: rtl/memory_bus_arbiter_if.sv
// Bundles the two requester ports and the memory_bus side of the arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface memory_bus_arbiter_if;
    logic        cpu_req;
    logic        cpu_write;
    logic [15:0] cpu_address;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_ack;

    logic        dma_req;
    logic        dma_write;
    logic [15:0] dma_address;
    logic [15:0] dma_data_in;
    logic [15:0] dma_data_out;
    logic        dma_ack;

    logic [15:0] mem_address;
    logic [15:0] mem_data_out;
    logic [15:0] mem_data_in;
    logic        mem_bus_enable;
    logic        mem_write_enable;
    logic        busy;

    modport slave (
        input  cpu_req, cpu_write, cpu_address, cpu_data_in,
        output cpu_data_out, cpu_ack,
        input  dma_req, dma_write, dma_address, dma_data_in,
        output dma_data_out, dma_ack,
        output mem_address, mem_data_out, mem_bus_enable, mem_write_enable,
        input  mem_data_in,
        output busy
    );

    modport master (
        output cpu_req, cpu_write, cpu_address, cpu_data_in,
        input  cpu_data_out, cpu_ack,
        output dma_req, dma_write, dma_address, dma_data_in,
        input  dma_data_out, dma_ack,
        input  mem_address, mem_data_out, mem_bus_enable, mem_write_enable,
        output mem_data_in,
        input  busy
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter between CPU and DMA for the single memory_bus port,
// inserting bank-dependent wait states with a req/ack handshake.
module memory_bus_arbiter #(
    parameter int WAIT_MEM    = 1,
    parameter int WAIT_PERIPH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    memory_bus_arbiter_if.slave         bus
);
    localparam int MAX_WAIT = (WAIT_MEM > WAIT_PERIPH) ? WAIT_MEM : WAIT_PERIPH;
    localparam int CNT_W    = $clog2(MAX_WAIT + 2);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t             state_q;
    logic               owner_dma_q;
    logic               last_dma_q;
    logic               wr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        addr_q;
    logic [15:0]        wdata_q;
    logic               en_q;
    logic               we_q;
    logic               cpu_ack_q;
    logic               dma_ack_q;
    logic               busy_q;
    logic [15:0]        cpu_rdata_q;
    logic [15:0]        dma_rdata_q;

    logic               grant_dma_d;
    logic               wr_d;
    logic [15:0]        addr_d;
    logic [15:0]        wdata_d;
    logic [CNT_W-1:0]   wait_d;

    // Requester selection: on a tie, the one that did not win last time.
    always_comb begin
        grant_dma_d = bus.dma_req;
        if (bus.cpu_req && bus.dma_req) begin
            grant_dma_d = ~last_dma_q;
        end
        wr_d    = grant_dma_d ? bus.dma_write   : bus.cpu_write;
        addr_d  = grant_dma_d ? bus.dma_address : bus.cpu_address;
        wdata_d = grant_dma_d ? bus.dma_data_in : bus.cpu_data_in;
        wait_d  = (addr_d[14:13] == 2'b10) ? CNT_W'(WAIT_PERIPH) : CNT_W'(WAIT_MEM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_dma_q <= 1'b0;
            last_dma_q  <= 1'b1;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        owner_dma_q <= grant_dma_d;
                        last_dma_q  <= grant_dma_d;
                        wr_q        <= wr_d;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        cnt_q       <= wait_d;
                        en_q        <= 1'b1;
                        we_q        <= wr_d && (wait_d == '0);
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= ACK;
                        if (owner_dma_q) begin
                            dma_ack_q <= 1'b1;
                            if (!wr_q) dma_rdata_q <= bus.mem_data_in;
                        end else begin
                            cpu_ack_q <= 1'b1;
                            if (!wr_q) cpu_rdata_q <= bus.mem_data_in;
                        end
                    end else begin
                        // Write strobe is raised only for the last access cycle.
                        cnt_q <= cnt_q - CNT_W'(1);
                        we_q  <= wr_q && (cnt_q == CNT_W'(1));
                    end
                end
                ACK: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_data_out     = cpu_rdata_q;
    assign bus.cpu_ack          = cpu_ack_q;
    assign bus.dma_data_out     = dma_rdata_q;
    assign bus.dma_ack          = dma_ack_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_data_out     = wdata_q;
    assign bus.mem_bus_enable   = en_q;
    assign bus.mem_write_enable = we_q;
    assign bus.busy             = busy_q;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: one instance with default wait states,
// a second with WAIT_MEM=2, each backed by a small word-addressed RAM model.
module tb_memory_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    memory_bus_arbiter_if bus1 ();
    memory_bus_arbiter_if bus2 ();

    memory_bus_arbiter #(.WAIT_MEM(1), .WAIT_PERIPH(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    memory_bus_arbiter #(.WAIT_MEM(2), .WAIT_PERIPH(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    logic [15:0] ram1 [256];
    logic [15:0] ram2 [256];

    assign bus1.mem_data_in = ram1[bus1.mem_address[7:0]];
    assign bus2.mem_data_in = ram2[bus2.mem_address[7:0]];

    always @(posedge clk) begin
        if (bus1.mem_bus_enable && bus1.mem_write_enable)
            ram1[bus1.mem_address[7:0]] <= bus1.mem_data_out;
        if (bus2.mem_bus_enable && bus2.mem_write_enable)
            ram2[bus2.mem_address[7:0]] <= bus2.mem_data_out;
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram1[i] <= 16'h0000;
            ram2[i] <= 16'h0000;
        end
        #0;
        ram1[8'h10] <= 16'h1234;
        ram1[8'h11] <= 16'h5678;
        ram1[8'h30] <= 16'hBEEF;
        ram2[8'h10] <= 16'h1234;
        ram2[8'h20] <= 16'hA5A5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.cpu_req = 0; bus1.cpu_write = 0; bus1.cpu_address = 0; bus1.cpu_data_in = 0;
        bus1.dma_req = 0; bus1.dma_write = 0; bus1.dma_address = 0; bus1.dma_data_in = 0;
        bus2.cpu_req = 0; bus2.cpu_write = 0; bus2.cpu_address = 0; bus2.cpu_data_in = 0;
        bus2.dma_req = 0; bus2.dma_write = 0; bus2.dma_address = 0; bus2.dma_data_in = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; reset2 = 1;
        tick();
        tick();
        reset = 0; reset2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; reset2 = 1;
        tick();
        tick();
        n_checks++;
        if ({bus1.busy, bus1.mem_bus_enable, bus1.mem_write_enable, bus1.cpu_ack, bus1.dma_ack} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {bus1.busy, bus1.mem_bus_enable, bus1.mem_write_enable, bus1.cpu_ack, bus1.dma_ack});
        end
        n_checks++;
        if ({bus1.mem_address, bus1.mem_data_out, bus1.cpu_data_out, bus1.dma_data_out} !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h expected 0", {bus1.mem_address, bus1.mem_data_out, bus1.cpu_data_out, bus1.dma_data_out});
        end
        n_checks++;
        if (bus2.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_busy2: got %b expected 0", bus2.busy);
        end
        reset = 0; reset2 = 0;
    endtask

    task automatic test_cpu_read();
        do_reset();
        bus1.cpu_req = 1; bus1.cpu_write = 0; bus1.cpu_address = 16'h0010;
        n_checks++;
        if (bus1.mem_bus_enable !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_c0_en: got %b expected 0", bus1.mem_bus_enable);
        end
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_checks++;
            if ({bus1.mem_bus_enable, bus1.mem_write_enable, bus1.busy, bus1.cpu_ack} !== 4'b1010) begin
                n_errors++;
                $display("FAIL rd_access_c%0d: got en/we/busy/ack=%b expected 1010", c, {bus1.mem_bus_enable, bus1.mem_write_enable, bus1.busy, bus1.cpu_ack});
            end
            n_checks++;
            if (bus1.mem_address !== 16'h0010) begin
                n_errors++;
                $display("FAIL rd_addr_c%0d: got %h expected 0010", c, bus1.mem_address);
            end
        end
        tick();
        n_checks++;
        if ({bus1.cpu_ack, bus1.dma_ack, bus1.mem_bus_enable} !== 3'b100) begin
            n_errors++;
            $display("FAIL rd_ack_c3: got cpu/dma/en=%b expected 100", {bus1.cpu_ack, bus1.dma_ack, bus1.mem_bus_enable});
        end
        n_checks++;
        if (bus1.cpu_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL rd_data: got %h expected 1234", bus1.cpu_data_out);
        end
        bus1.cpu_req = 0;
        tick();
        n_checks++;
        if ({bus1.cpu_ack, bus1.busy} !== 2'b00 || bus1.cpu_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL rd_after_ack: got ack/busy=%b data=%h expected 00 1234", {bus1.cpu_ack, bus1.busy}, bus1.cpu_data_out);
        end
    endtask

    task automatic test_dma_write();
        do_reset();
        bus1.dma_req = 1; bus1.dma_write = 1; bus1.dma_address = 16'h4005; bus1.dma_data_in = 16'h00FF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++;
            if ({bus1.mem_write_enable, bus1.mem_bus_enable, bus1.dma_ack, bus1.cpu_ack} !== {c == 3, c <= 3, c == 4, 1'b0}) begin
                n_errors++;
                $display("FAIL wr_c%0d: got we/en/dack/cack=%b expected %b", c, {bus1.mem_write_enable, bus1.mem_bus_enable, bus1.dma_ack, bus1.cpu_ack}, {c == 3, c <= 3, c == 4, 1'b0});
            end
            if (c == 3) begin
                n_checks++;
                if (bus1.mem_address !== 16'h4005 || bus1.mem_data_out !== 16'h00FF) begin
                    n_errors++;
                    $display("FAIL wr_bus: got addr=%h data=%h expected 4005 00FF", bus1.mem_address, bus1.mem_data_out);
                end
            end
        end
        n_checks++;
        if (ram1[8'h05] !== 16'h00FF) begin
            n_errors++;
            $display("FAIL wr_mem: got %h expected 00FF", ram1[8'h05]);
        end
        bus1.dma_req = 0; bus1.dma_write = 0;
        tick();
    endtask

    task automatic test_round_robin();
        int acks = 0;
        int order [4];
        int cyc [4];
        logic dbl = 1'b0;
        do_reset();
        bus1.cpu_req = 1; bus1.cpu_address = 16'h0010;
        bus1.dma_req = 1; bus1.dma_address = 16'h0011;
        for (int c = 1; c <= 40 && acks < 4; c++) begin
            tick();
            if (bus1.cpu_ack && bus1.dma_ack) dbl = 1'b1;
            if (bus1.cpu_ack) begin
                order[acks] = 0; cyc[acks] = c; acks++;
            end else if (bus1.dma_ack) begin
                order[acks] = 1; cyc[acks] = c; acks++;
            end
        end
        n_checks++;
        if (acks != 4 || dbl) begin
            n_errors++;
            $display("FAIL rr_acks: got %0d acks double=%b expected 4 acks double=0", acks, dbl);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != i % 2 || cyc[i] != 3 + 4 * i) begin
                    n_errors++;
                    $display("FAIL rr_grant%0d: got owner=%0d cycle=%0d expected owner=%0d cycle=%0d", i, order[i], cyc[i], i % 2, 3 + 4 * i);
                end
            end
        end
        n_checks++;
        if (bus1.cpu_data_out !== 16'h1234 || bus1.dma_data_out !== 16'h5678) begin
            n_errors++;
            $display("FAIL rr_data: got cpu=%h dma=%h expected 1234 5678", bus1.cpu_data_out, bus1.dma_data_out);
        end
        bus1.cpu_req = 0; bus1.dma_req = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus1.cpu_req = 1; bus1.cpu_address = 16'h0010;
        tick(); tick(); tick();
        n_checks++;
        if (bus1.cpu_ack !== 1'b1 || bus1.cpu_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL b2b_ack1: got ack=%b data=%h expected 1 1234", bus1.cpu_ack, bus1.cpu_data_out);
        end
        bus1.cpu_address = 16'h0011;
        tick();
        n_checks++;
        if ({bus1.mem_bus_enable, bus1.busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL b2b_idle_c4: got en/busy=%b expected 00", {bus1.mem_bus_enable, bus1.busy});
        end
        tick();
        n_checks++;
        if (bus1.mem_bus_enable !== 1'b1 || bus1.mem_address !== 16'h0011) begin
            n_errors++;
            $display("FAIL b2b_access_c5: got en=%b addr=%h expected 1 0011", bus1.mem_bus_enable, bus1.mem_address);
        end
        bus1.dma_req = 1; bus1.dma_address = 16'h0030;
        tick(); tick();
        n_checks++;
        if ({bus1.cpu_ack, bus1.dma_ack} !== 2'b10 || bus1.cpu_data_out !== 16'h5678) begin
            n_errors++;
            $display("FAIL b2b_ack2: got cack/dack=%b data=%h expected 10 5678", {bus1.cpu_ack, bus1.dma_ack}, bus1.cpu_data_out);
        end
        bus1.cpu_address = 16'h0010;
        tick(); tick();
        n_checks++;
        if (bus1.mem_address !== 16'h0030) begin
            n_errors++;
            $display("FAIL b2b_dma_grant: got addr=%h expected 0030", bus1.mem_address);
        end
        tick(); tick();
        n_checks++;
        if ({bus1.cpu_ack, bus1.dma_ack} !== 2'b01 || bus1.dma_data_out !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL b2b_dma_ack: got cack/dack=%b data=%h expected 01 BEEF", {bus1.cpu_ack, bus1.dma_ack}, bus1.dma_data_out);
        end
        bus1.dma_req = 0;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (bus1.cpu_ack !== 1'b1 || bus1.cpu_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL b2b_ack3: got ack=%b data=%h expected 1 1234", bus1.cpu_ack, bus1.cpu_data_out);
        end
        bus1.cpu_req = 0;
        tick();
    endtask

    task automatic test_wait2_read();
        do_reset();
        bus2.cpu_req = 1; bus2.cpu_address = 16'h0010;
        tick(); tick(); tick();
        n_checks++;
        if (bus2.mem_bus_enable !== 1'b1 || bus2.cpu_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL w2_c3: got en=%b ack=%b expected 1 0", bus2.mem_bus_enable, bus2.cpu_ack);
        end
        tick();
        n_checks++;
        if (bus2.cpu_ack !== 1'b1 || bus2.cpu_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL w2_ack_c4: got ack=%b data=%h expected 1 1234", bus2.cpu_ack, bus2.cpu_data_out);
        end
        bus2.cpu_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        logic saw_we = 1'b0;
        logic saw_ack = 1'b0;
        do_reset();
        bus2.cpu_req = 1; bus2.cpu_write = 1; bus2.cpu_address = 16'h0020; bus2.cpu_data_in = 16'hDEAD;
        tick();
        n_checks++;
        if ({bus2.mem_bus_enable, bus2.mem_write_enable} !== 2'b10) begin
            n_errors++;
            $display("FAIL rst_mid_c1: got en/we=%b expected 10", {bus2.mem_bus_enable, bus2.mem_write_enable});
        end
        reset2 = 1;
        bus2.cpu_req = 0; bus2.cpu_write = 0;
        tick();
        reset2 = 0;
        n_checks++;
        if ({bus2.busy, bus2.mem_bus_enable} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_mid_busy: got busy/en=%b expected 00", {bus2.busy, bus2.mem_bus_enable});
        end
        for (int c = 0; c < 6; c++) begin
            if (bus2.mem_write_enable) saw_we = 1'b1;
            if (bus2.cpu_ack) saw_ack = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_we || saw_ack) begin
            n_errors++;
            $display("FAIL rst_mid_strobes: got we=%b ack=%b expected 0 0", saw_we, saw_ack);
        end
        n_checks++;
        if (ram2[8'h20] !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL rst_mid_mem: got %h expected A5A5", ram2[8'h20]);
        end
    endtask

    task automatic test_addr_stability();
        do_reset();
        bus1.cpu_req = 1; bus1.cpu_address = 16'h0010;
        tick();
        bus1.cpu_address = 16'h0030;
        n_checks++;
        if (bus1.mem_address !== 16'h0010) begin
            n_errors++;
            $display("FAIL stab_c1: got %h expected 0010", bus1.mem_address);
        end
        tick();
        n_checks++;
        if (bus1.mem_address !== 16'h0010) begin
            n_errors++;
            $display("FAIL stab_c2: got %h expected 0010", bus1.mem_address);
        end
        tick();
        n_checks++;
        if (bus1.cpu_ack !== 1'b1 || bus1.cpu_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL stab_data: got ack=%b data=%h expected 1 1234", bus1.cpu_ack, bus1.cpu_data_out);
        end
        bus1.cpu_req = 0;
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1; reset2 = 1;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_round_robin();
        test_back_to_back();
        test_wait2_read();
        test_reset_mid_write();
        test_addr_stability();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
